// File: rtl/half_adder_if.sv
// Operand/result handshake bundle for half_adder: operand channel (in_*, a, b)
// and result channel (out_*, s, c, carry_any).
interface half_adder_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;
  logic             carry_any;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, s, c, carry_any
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, s, c, carry_any
  );
endinterface

// File: rtl/half_adder.sv
// Registered multi-lane half adder with a one-entry valid/ready output stage
// and saturating operation/carry statistics counters.
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  half_adder_if.slave      bus,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] carry_count
);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             carry_any_q, carry_any_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [CNT_W-1:0] carry_count_q, carry_count_d;

  logic             in_ready_s;
  logic             in_xfer_s;
  logic [WIDTH-1:0] carry_bits_s;

  // The single result slot frees up whenever the consumer drains it this cycle.
  assign in_ready_s   = ~out_valid_q | bus.out_ready;
  assign in_xfer_s    = bus.in_valid & in_ready_s;
  assign carry_bits_s = bus.a & bus.b;

  // Next-state logic for the result slot and statistics counters.
  always_comb begin
    out_valid_d   = out_valid_q;
    s_d           = s_q;
    c_d           = c_q;
    carry_any_d   = carry_any_q;
    op_count_d    = op_count_q;
    carry_count_d = carry_count_q;
    if (in_xfer_s) begin
      out_valid_d = 1'b1;
      s_d         = bus.a ^ bus.b;
      c_d         = carry_bits_s;
      carry_any_d = |carry_bits_s;
      op_count_d  = sat_inc(op_count_q);
      if (|carry_bits_s) begin
        carry_count_d = sat_inc(carry_count_q);
      end else begin
        carry_count_d = carry_count_q;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset discards any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      s_q           <= {WIDTH{1'b0}};
      c_q           <= {WIDTH{1'b0}};
      carry_any_q   <= 1'b0;
      op_count_q    <= {CNT_W{1'b0}};
      carry_count_q <= {CNT_W{1'b0}};
    end else begin
      out_valid_q   <= out_valid_d;
      s_q           <= s_d;
      c_q           <= c_d;
      carry_any_q   <= carry_any_d;
      op_count_q    <= op_count_d;
      carry_count_q <= carry_count_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.c         = c_q;
  assign bus.carry_any = carry_any_q;
  assign op_count      = op_count_q;
  assign carry_count   = carry_count_q;

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: truth table, lanes, backpressure, streaming,
// counter saturation and mid-operation reset, with a result scoreboard.
module tb_half_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  half_adder_if #(.WIDTH(1)) if1 ();
  half_adder_if #(.WIDTH(4)) if4 ();
  half_adder_if #(.WIDTH(1)) ifs ();

  logic [15:0] op1, cc1, op4, cc4;
  logic [1:0]  ops, ccs;

  half_adder #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .op_count(op1), .carry_count(cc1));
  half_adder #(.WIDTH(4), .CNT_W(16)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave), .op_count(op4), .carry_count(cc4));
  half_adder #(.WIDTH(1), .CNT_W(2)) us (
    .clk(clk), .rst_n(rst_n), .bus(ifs.slave), .op_count(ops), .carry_count(ccs));

  int total = 0;
  int bad = 0;
  int pops = 0;
  logic [2:0] sbq[$];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on u1: score the output transfer, log the input transfer.
  task automatic step1();
    logic [2:0] e;
    @(negedge clk);
    if (if1.out_valid && if1.out_ready) begin
      chk("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("result_s_c_any", {29'd0, if1.s, if1.c, if1.carry_any}, {29'd0, e});
        pops++;
      end
    end
    if (if1.in_valid && if1.in_ready)
      sbq.push_back({if1.a ^ if1.b, if1.a & if1.b, if1.a & if1.b});
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    if1.in_valid = 1'b0; if1.a = 1'b0; if1.b = 1'b0; if1.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.a = 4'd0; if4.b = 4'd0; if4.out_ready = 1'b0;
    ifs.in_valid = 1'b0; ifs.a = 1'b0; ifs.b = 1'b0; ifs.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(if1.out_valid), 32'd0);
    chk("rst_s_c_any", {29'd0, if1.s, if1.c, if1.carry_any}, 32'd0);
    chk("rst_in_ready", 32'(if1.in_ready), 32'd1);
    chk("rst_op_count", 32'(op1), 32'd0);
    chk("rst_carry_count", 32'(cc1), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Truth table, back to back
    if1.out_ready = 1'b1;
    if1.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {if1.a, if1.b} = 2'(i);
      step1();
    end
    if1.in_valid = 1'b0;
    step1();
    step1();
    chk("tt_op_count", 32'(op1), 32'd4);
    chk("tt_carry_count", 32'(cc1), 32'd1);
    chk("tt_sb_empty", 32'(sbq.size()), 32'd0);

    // Backpressure
    pulse_reset();
    if1.out_ready = 1'b0;
    if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b1;
    step1();
    if1.a = 1'b0; if1.b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(if1.in_ready), 32'd0);
      chk("bp_out_valid", 32'(if1.out_valid), 32'd1);
      chk("bp_held_s_c", {30'd0, if1.s, if1.c}, 32'd1);
      step1();
    end
    if1.out_ready = 1'b1;
    step1();
    if1.in_valid = 1'b0;
    step1();
    chk("bp_op_count", 32'(op1), 32'd2);
    chk("bp_carry_count", 32'(cc1), 32'd1);

    // Streaming
    pops = 0;
    if1.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if1.a = 1'($urandom);
      if1.b = 1'($urandom);
      chk("st_in_ready", 32'(if1.in_ready), 32'd1);
      if (i > 0) chk("st_out_valid", 32'(if1.out_valid), 32'd1);
      step1();
    end
    if1.in_valid = 1'b0;
    step1();
    chk("st_result_count", 32'(pops), 32'd8);
    chk("st_sb_empty", 32'(sbq.size()), 32'd0);

    // Reset while a result is stalled
    if1.out_ready = 1'b0;
    if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b1;
    step1();
    if1.in_valid = 1'b0;
    chk("mr_pending", 32'(if1.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    sbq.delete();
    chk("mr_out_valid", 32'(if1.out_valid), 32'd0);
    chk("mr_s_c_any", {29'd0, if1.s, if1.c, if1.carry_any}, 32'd0);
    chk("mr_counts", {op1, cc1}, 32'd0);
    chk("mr_in_ready", 32'(if1.in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("mr_held_in_reset", 32'(if1.out_valid), 32'd0);
    rst_n = 1'b1;
    if1.out_ready = 1'b1;
    if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b0;
    step1();
    if1.in_valid = 1'b0;
    step1();
    chk("mr_op_after", 32'(op1), 32'd1);

    // Independent lanes
    if4.out_ready = 1'b1;
    if4.in_valid = 1'b1; if4.a = 4'b1100; if4.b = 4'b1010;
    @(posedge clk);
    #1;
    chk("ln_out_valid", 32'(if4.out_valid), 32'd1);
    chk("ln_s", 32'(if4.s), 32'h6);
    chk("ln_c", 32'(if4.c), 32'h8);
    chk("ln_carry_any", 32'(if4.carry_any), 32'd1);
    if4.a = 4'b0101; if4.b = 4'b1010;
    @(posedge clk);
    #1;
    if4.in_valid = 1'b0;
    chk("ln_s_nocarry", 32'(if4.s), 32'hF);
    chk("ln_carry_any_0", 32'(if4.carry_any), 32'd0);
    chk("ln_counts", {op4, cc4}, {16'd2, 16'd1});

    // Counter saturation
    ifs.out_ready = 1'b1;
    ifs.in_valid = 1'b1; ifs.a = 1'b1; ifs.b = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      chk("sat_op_count", 32'(ops), (i < 3) ? i : 32'd3);
    end
    ifs.in_valid = 1'b0;
    chk("sat_carry_count", 32'(ccs), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter WIDTH SHALL default to 1: number of independent half-adder bit lanes, legal range 1..32.
REQ-003 Parameter CNT_W SHALL default to 16: width of the statistics counters, legal range 2..32.
REQ-004 Port clk SHALL be an input of width 1: rising-edge clock for all state.
REQ-005 Port rst_n SHALL be an input of width 1: asynchronous active-low reset.
REQ-006 Port in_valid SHALL be an input of width 1: an operand pair is presented.
REQ-007 Port in_ready SHALL be an output of width 1: the block accepts an operand pair this cycle.
REQ-008 Port a SHALL be an input of width WIDTH: addend.
REQ-009 Port b SHALL be an input of width WIDTH: augend.
REQ-010 Port out_valid SHALL be an output of width 1: s, c and carry_any hold a result.
REQ-011 Port out_ready SHALL be an input of width 1: the consumer takes the result this cycle.
REQ-012 Port s SHALL be an output of width WIDTH: per-lane sum.
REQ-013 Port c SHALL be an output of width WIDTH: per-lane carry.
REQ-014 Port carry_any SHALL be an output of width 1: OR-reduction of c.
REQ-015 Port op_count SHALL be an output of width CNT_W: number of accepted operand pairs.
REQ-016 Port carry_count SHALL be an output of width CNT_W: number of accepted pairs that produced at least one carry bit.

Function
REQ-017 Each lane i SHALL compute s[i] = a[i] XOR b[i] and c[i] = a[i] AND b[i], with no carry propagation between lanes.
REQ-018 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-019 in_ready SHALL equal (NOT out_valid) OR out_ready, combinationally.
REQ-020 On an input transfer, s, c and carry_any SHALL be registered from a and b, and out_valid SHALL be 1 on the following cycle (latency 1 cycle).
REQ-021 An output transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-022 When an output transfer coincides with an input transfer, the new result SHALL load and out_valid SHALL remain 1, so back-to-back throughput is 1 result per cycle.
REQ-023 When an output transfer occurs with no input transfer, out_valid SHALL go to 0; s, c and carry_any SHALL hold their last values.
REQ-024 While out_valid=1 and out_ready=0, s, c, carry_any and out_valid SHALL remain unchanged, and no input SHALL be accepted.
REQ-025 a and b SHALL be ignored when no input transfer occurs.
REQ-026 op_count SHALL increment by 1 on each input transfer and saturate at 2^CNT_W-1; it SHALL NOT wrap around.
REQ-027 carry_count SHALL increment by 1 on each input transfer where (a AND b) is non-zero, and saturate at 2^CNT_W-1.
REQ-028 Counters SHALL update in the same edge as the input transfer and be visible on the next cycle.
REQ-029 All outputs other than in_ready SHALL be driven directly from registers.

Reset
REQ-030 When rst_n=0, out_valid, s, c, carry_any, op_count and carry_count SHALL clear to 0 immediately, regardless of clk.
REQ-031 During and after reset, in_ready SHALL be 1, since out_valid=0.
REQ-032 A result pending at reset assertion SHALL be discarded.
REQ-033 The first input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-034 Truth table: WIDTH=1, out_ready=1, apply (a,b) = (0,0), (0,1), (1,0), (1,1) on consecutive cycles -> (s,c) = (0,0), (1,0), (1,0), (0,1), each one cycle later; afterwards op_count=4 and carry_count=1.
REQ-035 Lanes: WIDTH=4, a=4'b1100, b=4'b1010 -> s=4'b0110, c=4'b1000, carry_any=1.
REQ-036 Backpressure: out_ready=0 after accepting (1,1) -> out_valid=1, s=0, c=1 held, and in_ready=0 for 3 cycles with input (0,1) offered and not accepted; then out_ready=1 -> (0,1) is accepted, next result is s=1, c=0, and op_count=2.
REQ-037 Streaming: in_valid=1 and out_ready=1 for 8 cycles -> 8 results on consecutive cycles, and in_ready stays 1.
REQ-038 Saturation: CNT_W=2, apply 6 pairs with carry -> op_count=3 and carry_count=3, with no wrap.
REQ-039 Reset mid-operation: assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid, s, c, carry_any and both counters are 0 immediately, in_ready=1, and normal operation follows from the next edge after release.
